// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for VGA-style displays. A clock divider produces a
// pixel tick every CLK_DIV clocks. Each tick advances a column/line counter
// pair. Registered video_on, hsync and vsync follow the counters and stay
// aligned with them.
//
// Parameters
//   H_ACTIVE/H_FP/H_SYNC/H_BP : horizontal visible, front porch, sync and
//                               back porch widths, in pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP : vertical equivalents, in lines
//   HS_POL/VS_POL             : active sync level (0 = active-low)
//   CLK_DIV                   : clk cycles per pixel (1..16)
//   CW                        : width of the x/y outputs
//
// Ports
//   clk         in   single clock; all state changes on the rising edge
//   reset       in   asynchronous reset, active low
//   run         in   1 = timing advances, 0 = everything holds
//   restart     in   synchronous return to the end-of-frame state
//                    (frame_cnt is kept)
//   pix_en      out  one-clk pixel tick
//   x, y        out  current pixel column and line
//   video_on    out  high inside the visible area
//   hsync/vsync out  sync outputs at the polarity set by HS_POL/VS_POL
//   line_start  out  one-clk pulse on the edge after the tick that loads x=0
//   frame_start out  one-clk pulse on the edge after the tick that loads
//                    x=0,y=0
//   frame_cnt   out  frame counter, counts modulo 256
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          restart,
  output logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider width. At least one bit is kept so that CLK_DIV=1 still elaborates.
  // In that case the divider is constantly 0.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);

  // The sync windows are held as inclusive first/last bounds. Every bound is
  // then below H_TOTAL/V_TOTAL, so each one fits in CW bits even when the back
  // porch is zero.
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_ON  = HS_POL;
  localparam logic HS_OFF = ~HS_POL;
  localparam logic VS_ON  = VS_POL;
  localparam logic VS_OFF = ~VS_POL;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_q,   div_d;
  logic [CW-1:0] x_q,     x_d;
  logic [CW-1:0] y_q,     y_d;
  logic          video_q, video_d;
  logic          hs_q,    hs_d;
  logic          vs_q,    vs_d;
  logic          tick_q,  tick_d;   // a pixel tick happened on the last run edge
  logic          ls_q,    ls_d;
  logic          fs_q,    fs_d;
  logic [7:0]    fc_q,    fc_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic          tick;
  logic          x_wrap;
  logic [CW-1:0] x_nx;
  logic [CW-1:0] y_nx;

  always_comb begin
    tick   = run && (div_q == DIV_LAST);
    x_wrap = (x_q == H_LAST);
    x_nx   = x_wrap ? '0 : x_q + 1'b1;
    if (x_wrap) begin
      y_nx = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end else begin
      y_nx = y_q;
    end

    div_d   = div_q;
    x_d     = x_q;
    y_d     = y_q;
    video_d = video_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    tick_d  = tick_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    fc_d    = fc_q;

    if (run) begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_d = tick;
      // The pulses fire on the edge after the tick that loaded x=0. tick_q is
      // frozen while run=0, so a pulse that falls inside a pause comes out on
      // the first running edge instead of being lost.
      ls_d   = tick_q && (x_q == '0);
      fs_d   = ls_d && (y_q == '0);
    end

    // Sync and blanking are decoded from the incoming counter values. They are
    // registered on the same edge as x/y, so all of them stay aligned.
    if (tick) begin
      x_d     = x_nx;
      y_d     = y_nx;
      video_d = (x_nx <= H_ACT_LAST) && (y_nx <= V_ACT_LAST);
      hs_d    = ((x_nx >= HS_FIRST) && (x_nx <= HS_LAST)) ? HS_ON : HS_OFF;
      vs_d    = ((y_nx >= VS_FIRST) && (y_nx <= VS_LAST)) ? VS_ON : VS_OFF;
    end

    if (fs_d) begin
      fc_d = fc_q + 8'd1;
    end

    // restart wins over run and over any tick on the same edge. The frame
    // counter keeps its value.
    if (restart) begin
      div_d   = '0;
      x_d     = H_LAST;
      y_d     = V_LAST;
      video_d = 1'b0;
      hs_d    = HS_OFF;
      vs_d    = VS_OFF;
      tick_d  = 1'b0;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      fc_d    = fc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      video_q <= 1'b0;
      hs_q    <= HS_OFF;
      vs_q    <= VS_OFF;
      tick_q  <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      video_q <= video_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      tick_q  <= tick_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // pix_en is decoded from the divider so that it is low for the whole pause
  // when run=0. With CLK_DIV=1 the divider is constant, so reset must also be
  // in the term: pix_en would otherwise follow run while reset is asserted.
  assign pix_en      = tick & reset;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; sampling happens 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // DUT A: all defaults (640x480, CLK_DIV=2)
  // ---------------------------------------------------------------------------
  logic a_rst = 1'b0, a_run = 1'b0, a_rs = 1'b0;
  logic a_pix, a_vid, a_hs, a_vs, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;

  vga_timing_gen u_a (
    .clk(clk), .reset(a_rst), .run(a_run), .restart(a_rs),
    .pix_en(a_pix), .x(a_x), .y(a_y), .video_on(a_vid),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs),
    .frame_cnt(a_fc)
  );

  // ---------------------------------------------------------------------------
  // DUT B: defaults with CLK_DIV=1
  // ---------------------------------------------------------------------------
  logic b_rst = 1'b0, b_run = 1'b0, b_rs = 1'b0;
  logic b_pix, b_vid, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;

  vga_timing_gen #(.CLK_DIV(1)) u_b (
    .clk(clk), .reset(b_rst), .run(b_run), .restart(b_rs),
    .pix_en(b_pix), .x(b_x), .y(b_y), .video_on(b_vid),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs),
    .frame_cnt(b_fc)
  );

  // ---------------------------------------------------------------------------
  // DUT C: 800x600, positive syncs, CLK_DIV=1
  // ---------------------------------------------------------------------------
  logic c_rst = 1'b0, c_run = 1'b0, c_rs = 1'b0;
  logic c_pix, c_vid, c_hs, c_vs, c_ls, c_fs;
  logic [10:0] c_x, c_y;
  logic [7:0] c_fc;

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1),  .V_SYNC(4),   .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(11)
  ) u_c (
    .clk(clk), .reset(c_rst), .run(c_run), .restart(c_rs),
    .pix_en(c_pix), .x(c_x), .y(c_y), .video_on(c_vid),
    .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs),
    .frame_cnt(c_fc)
  );

  // ---------------------------------------------------------------------------
  // DUT D: tiny raster (15x11 total), positive syncs, CLK_DIV=1, CW=4
  // ---------------------------------------------------------------------------
  logic d_rst = 1'b0, d_run = 1'b0, d_rs = 1'b0;
  logic d_pix, d_vid, d_hs, d_vs, d_ls, d_fs;
  logic [3:0] d_x, d_y;
  logic [7:0] d_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(4)
  ) u_d (
    .clk(clk), .reset(d_rst), .run(d_run), .restart(d_rs),
    .pix_en(d_pix), .x(d_x), .y(d_y), .video_on(d_vid),
    .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs),
    .frame_cnt(d_fc)
  );

  // ---------------------------------------------------------------------------
  // Stimulus and checks
  // ---------------------------------------------------------------------------
  initial begin
    int hs_first, hs_last, hs_clk, vid_clk, period, bad, lat;
    int pz, ls1, ls2, run_len, run_max;
    int fs_n, last_fs, bad_period, bad_fc, oor, vs_first, vs_last, exp_fc, fc_at256;

    step(3);

    // ---- A: reset state ----
    check_val("a_rst_x", a_x, 799);
    check_val("a_rst_y", a_y, 524);
    check_val("a_rst_vid", a_vid, 0);
    check_val("a_rst_hs", a_hs, 1);
    check_val("a_rst_vs", a_vs, 1);
    check_val("a_rst_pix", a_pix, 0);
    check_val("a_rst_pulses", {a_ls, a_fs}, 0);
    check_val("a_rst_fc", a_fc, 0);

    // ---- A: first tick after release ----
    a_rst = 1'b1;
    a_run = 1'b1;
    step(1);
    check_val("a_clk1_x", a_x, 799);
    check_val("a_clk1_pix", a_pix, 1);
    step(1);
    check_val("a_clk2_x", a_x, 0);
    check_val("a_clk2_y", a_y, 0);
    check_val("a_clk2_vid", a_vid, 1);
    check_val("a_clk2_ls", a_ls, 0);
    step(1);
    check_val("a_ls_first", a_ls, 1);
    check_val("a_fs_first", a_fs, 1);
    check_val("a_fc_first", a_fc, 1);

    // ---- A: one full line, hsync window and line period ----
    hs_first = -1; hs_last = -1; hs_clk = 0; vid_clk = 0; period = -1;
    for (int c = 0; c < 2000; c++) begin
      if (c > 0 && a_ls) begin
        period = c;
        break;
      end
      if (!a_hs) begin
        if (hs_first < 0) hs_first = a_x;
        hs_last = a_x;
        hs_clk++;
      end
      if (a_vid) vid_clk++;
      step(1);
    end
    check_val("a_line_period", period, 1600);
    check_val("a_hs_first_x", hs_first, 656);
    check_val("a_hs_last_x", hs_last, 751);
    check_val("a_hs_clks", hs_clk, 192);
    check_val("a_vid_clks", vid_clk, 1280);
    check_val("a_line1_y", a_y, 1);
    check_val("a_line1_vs", a_vs, 1);

    // ---- A: freeze at x=639 for 37 clk ----
    for (int c = 0; c < 2000; c++) begin
      if (a_x == 10'd639) break;
      step(1);
    end
    check_val("a_reach_639", a_x, 639);
    a_run = 1'b0;
    bad = 0;
    for (int c = 0; c < 37; c++) begin
      step(1);
      if (a_pix || a_x != 10'd639 || a_y != 10'd1 || !a_vid || !a_hs || !a_vs || a_ls || a_fs)
        bad++;
    end
    check_val("a_freeze_bad_clks", bad, 0);
    a_run = 1'b1;
    lat = -1;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      if (a_x != 10'd639) begin
        lat = c;
        break;
      end
    end
    check_val("a_resume_latency", lat, 2);
    check_val("a_resume_x", a_x, 640);
    check_val("a_resume_vid", a_vid, 0);

    // ---- A: async reset mid-line while hsync is active ----
    for (int c = 0; c < 400; c++) begin
      if (a_x == 10'd700) break;
      step(1);
    end
    check_val("a_x700_hs", a_hs, 0);
    #2 a_rst = 1'b0;
    #1;
    check_val("a_async_x", a_x, 799);
    check_val("a_async_y", a_y, 524);
    check_val("a_async_hs", a_hs, 1);
    check_val("a_async_vid", a_vid, 0);
    check_val("a_async_pix", a_pix, 0);
    check_val("a_async_fc", a_fc, 0);
    a_run = 1'b0;
    step(1);

    // ---- B: CLK_DIV=1 ----
    check_val("b_rst_pix", b_pix, 0);
    b_rst = 1'b1;
    b_run = 1'b1;
    step(1);
    check_val("b_clk1_x", b_x, 0);
    check_val("b_clk1_y", b_y, 0);
    pz = 0; ls1 = -1; ls2 = -1; run_len = 0; run_max = 0;
    for (int c = 0; c < 1700; c++) begin
      if (!b_pix) pz++;
      if (b_ls) begin
        if (ls1 < 0) ls1 = c;
        else if (ls2 < 0) ls2 = c;
      end
      if (b_vid) begin
        run_len++;
        if (run_len > run_max) run_max = run_len;
      end else begin
        run_len = 0;
      end
      step(1);
    end
    check_val("b_pix_low_clks", pz, 0);
    check_val("b_line_period", (ls1 >= 0 && ls2 >= 0) ? ls2 - ls1 : -1, 800);
    check_val("b_vid_run", run_max, 640);
    b_run = 1'b0;

    // ---- C: 800x600, positive polarity ----
    check_val("c_rst_hs", c_hs, 0);
    check_val("c_rst_vs", c_vs, 0);
    c_rst = 1'b1;
    c_run = 1'b1;
    hs_first = -1; hs_last = -1; bad = 0;
    for (int c = 0; c < 1100; c++) begin
      if (c_hs) begin
        if (hs_first < 0) hs_first = c_x;
        hs_last = c_x;
      end
      if (c_vs) bad++;
      step(1);
    end
    check_val("c_hs_first_x", hs_first, 840);
    check_val("c_hs_last_x", hs_last, 967);
    check_val("c_vs_line0_clks", bad, 0);
    c_run = 1'b0;

    // ---- D: tiny raster, frame period, vsync window, counter wrap ----
    check_val("d_rst_x", d_x, 14);
    check_val("d_rst_y", d_y, 10);
    d_rst = 1'b1;
    d_run = 1'b1;
    fs_n = 0; last_fs = -1; bad_period = 0; bad_fc = 0; oor = 0;
    vs_first = -1; vs_last = -1; exp_fc = 0; fc_at256 = -1;
    for (int c = 0; c < 44000; c++) begin
      if (d_x >= 4'd15 || d_y >= 4'd11) oor++;
      if (d_fs) begin
        fs_n++;
        exp_fc = (exp_fc + 1) % 256;
        if (d_fc != 8'(exp_fc)) bad_fc++;
        if (last_fs >= 0 && c - last_fs != 165) bad_period++;
        last_fs = c;
        if (fs_n == 256) fc_at256 = d_fc;
        if (fs_n == 261) break;
      end
      if (fs_n == 1 && d_vs) begin
        if (vs_first < 0) vs_first = d_y;
        vs_last = d_y;
      end
      step(1);
    end
    check_val("d_frames", fs_n, 261);
    check_val("d_fc_mismatch_frames", bad_fc, 0);
    check_val("d_bad_frame_period", bad_period, 0);
    check_val("d_out_of_range", oor, 0);
    check_val("d_fc_wrap", fc_at256, 0);
    check_val("d_vs_first_y", vs_first, 7);
    check_val("d_vs_last_y", vs_last, 8);
    check_val("d_fc_before_restart", d_fc, 5);

    // ---- D: restart coincident with a tick ----
    for (int c = 0; c < 200; c++) begin
      if (d_x == 4'd5 && d_y == 4'd3) break;
      step(1);
    end
    check_val("d_pre_restart_pix", d_pix, 1);
    d_rs = 1'b1;
    step(1);
    d_rs = 1'b0;
    check_val("d_restart_x", d_x, 14);
    check_val("d_restart_y", d_y, 10);
    check_val("d_restart_fc", d_fc, 5);
    check_val("d_restart_syncs", {d_hs, d_vs, d_vid}, 0);
    step(1);
    check_val("d_post_x", d_x, 0);
    check_val("d_post_y", d_y, 0);
    check_val("d_post_fs", d_fs, 0);
    step(1);
    check_val("d_post_fs_pulse", d_fs, 1);
    check_val("d_post_fc", d_fc, 6);
    step(1);
    check_val("d_fs_one_clk", d_fs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL provide parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 SHALL provide parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL provide parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical equivalents in lines.
REQ-006 SHALL provide parameters HS_POL and VS_POL, default 0, active sync level (0 = active-low).
REQ-007 SHALL provide parameter CLK_DIV, default 2, clk cycles per pixel (legal 1..16).
REQ-008 SHALL provide parameter CW, default 10, width of x/y outputs.
REQ-009 SHALL provide port clk, input, 1, single clock; all state on rising edge.
REQ-010 SHALL provide port reset, input, 1, asynchronous active-low reset.
REQ-011 SHALL provide port run, input, 1, 1 = timing advances, 0 = freeze.
REQ-012 SHALL provide port restart, input, 1, synchronous return to end-of-frame state.
REQ-013 SHALL provide port pix_en, output, 1, one-clk pixel tick.
REQ-014 SHALL provide ports x and y, output, CW each, current pixel column and line.
REQ-015 SHALL provide port video_on, output, 1, high when x<H_ACTIVE and y<V_ACTIVE.
REQ-016 SHALL provide ports hsync and vsync, output, 1 each, polarity per HS_POL/VS_POL.
REQ-017 SHALL provide ports line_start and frame_start, output, 1 each, one-clk pulses.
REQ-018 SHALL provide port frame_cnt, output, 8, frame counter.

Function
REQ-019 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise.
REQ-020 SHALL run a divider 0..CLK_DIV-1 while run=1; pix_en=1 for the single clk in which divider=CLK_DIV-1; with CLK_DIV=1, pix_en=run.
REQ-021 SHALL advance x, y, video_on, hsync, vsync only on edges where pix_en=1; all are registered, mutually aligned, zero skew.
REQ-022 SHALL increment x each tick; at x=H_TOTAL-1, x wraps to 0 and y increments; at y=V_TOTAL-1 with x wrap, y wraps to 0.
REQ-023 SHALL drive hsync active while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, else inactive.
REQ-024 SHALL drive vsync active while V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, else inactive.
REQ-025 SHALL pulse line_start for one clk on the edge following the tick that loads x=0.
REQ-026 SHALL pulse frame_start for one clk on the edge following the tick that loads x=0,y=0; frame_cnt increments (mod 256) on the same edge.
REQ-027 SHALL, with run=0, hold divider, counters and all level outputs; pix_en, line_start and frame_start stay 0; on run=1, resume from the held divider value without skip or repeat.
REQ-028 SHALL, on restart=1, load the reset state (REQ-030) on that edge, except frame_cnt, which is held; restart overrides run and any coincident tick.
REQ-029 SHALL produce no out-of-range x/y values (x<H_TOTAL, y<V_TOTAL at all times).

Reset
REQ-030 SHALL, while reset=0, asynchronously force: divider=0, x=H_TOTAL-1, y=V_TOTAL-1, video_on=0, hsync=~HS_POL, vsync=~VS_POL, pix_en=0, line_start=0, frame_start=0, frame_cnt=0.
REQ-031 SHALL, after reset release with run=1, make the first pix_en tick wrap x,y to 0,0, with frame_start and line_start on the following edge.
REQ-032 SHALL tolerate reset assertion at any point mid-frame with no output glitch beyond the forced reset values.

Verification
REQ-033 SHALL verify defaults, run=1: x=0,y=0 after 2 clk; hsync low x=656..751; vsync low y=490..491; frame_start every 2*800*525=840000 clk.
REQ-034 SHALL verify CLK_DIV=1: pix_en constant 1; line period exactly 800 clk; video_on high 640 consecutive clk per active line.
REQ-035 SHALL verify run=0 for 37 clk at x=639,y=100: all outputs frozen, pix_en=0; after run=1, next tick gives x=640 and video_on=0.
REQ-036 SHALL verify restart with coincident run=1 tick at x=200,y=300, frame_cnt=5: next state x=799,y=524, frame_cnt=5; next tick gives frame_start and frame_cnt=6.
REQ-037 SHALL verify reset asserted mid-line (x=700, hsync active): outputs go to REQ-030 values without a clock edge.
REQ-038 SHALL verify HS_POL=1, VS_POL=1, 800x600 (H 40/128/88, V 1/4/23): hsync high x=840..967, vsync high y=601..604, frame_cnt wraps 255->0.
